fetch_inst_queue: RTL and testbench

- Instruction queue between IF (bundle fetch + IJTC/BTB prediction) and ID.
- Accepts aligned fetch bundles of up to 4 instructions per cycle. Each instruction carries its PC, predicted destination and predicted-take bit.
- Presents up to 2 instructions per cycle to decode, in program order.
- Flushed entirely on back-end branch repair.

---
 rtl/fetch_inst_queue.sv | 125 ++++++++++++
 tb/tb_fetch_inst_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_inst_queue
//  Purpose  : Instruction queue between IF and ID. Accepts up to 4 aligned
//             fetch lanes per cycle (inst, PC, predicted dest, predicted
//             take), presents up to 2 oldest entries per cycle to decode,
//             and is emptied on back-end branch repair.
//  Options  : FIQ_STALL_CNT_EN adds stall_cnt_o, a saturating count of
//             cycles in which IF offered a bundle that could not be taken.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               in_valid_i,
    input  logic [2:0]         in_count_i,
    input  logic [127:0]       in_inst_i,
    input  logic [127:0]       in_pc_i,
    input  logic [127:0]       in_dest_i,
    input  logic [3:0]         in_take_i,
    output logic               in_ready_o,
    output logic [1:0]         out_valid_o,
    output logic [63:0]        out_inst_o,
    output logic [63:0]        out_pc_o,
    output logic [63:0]        out_dest_o,
    output logic [1:0]         out_take_o,
    input  logic [1:0]         out_pop_i,
    output logic [PTR_W:0]     occupancy_o
`ifdef FIQ_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    // Highest occupancy at which a full 4-lane bundle still fits.
    localparam logic [PTR_W:0] c_READY_MAX = (PTR_W+1)'(DEPTH - 4);

    // Entry layout: {take[96], dest[95:64], pc[63:32], inst[31:0]}
    logic [96:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_cnt_ok;
    logic [2:0]       w_push_n;
    logic [1:0]       w_avail;
    logic [1:0]       w_pop_n;
    logic [PTR_W-1:0] w_head1;
    logic [96:0]      w_rd0;
    logic [96:0]      w_rd1;

    // Ready and visibility are taken from registered count only; a same-cycle
    // pop is deliberately not credited so in_ready_o has no input path.
    always_comb begin
        in_ready_o  = (r_count <= c_READY_MAX);
        w_cnt_ok    = (in_count_i != 3'd0) && (in_count_i <= 3'd4);
        w_push_n    = (in_valid_i && in_ready_o && w_cnt_ok && !flush_i) ? in_count_i : 3'd0;
        w_avail     = (r_count == '0) ? 2'd0 :
                      (r_count == (PTR_W+1)'(1)) ? 2'd1 : 2'd2;
        w_pop_n     = (out_pop_i > w_avail) ? w_avail : out_pop_i;
        out_valid_o = {(r_count >= (PTR_W+1)'(2)), (r_count != '0)};
        occupancy_o = r_count;
    end

    // Read the two oldest entries; slot 1 wraps with the pointer arithmetic.
    always_comb begin
        w_head1    = r_head + PTR_W'(1);
        w_rd0      = r_mem[r_head];
        w_rd1      = r_mem[w_head1];
        out_inst_o = {w_rd1[31:0],  w_rd0[31:0]};
        out_pc_o   = {w_rd1[63:32], w_rd0[63:32]};
        out_dest_o = {w_rd1[95:64], w_rd0[95:64]};
        out_take_o = {w_rd1[96],    w_rd0[96]};
    end

    // Pointer and occupancy update; flush has priority over push and pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop_n);
        end
    end

    // Lane n lands at tail+n; modulo-DEPTH wrap comes from the pointer width.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (3'(l) < w_push_n) begin
                r_mem[r_tail + PTR_W'(l)] <= {in_take_i[l],
                                              in_dest_i[32*l +: 32],
                                              in_pc_i[32*l +: 32],
                                              in_inst_i[32*l +: 32]};
            end
        end
    end

`ifdef FIQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count blocked-fetch cycles; saturating, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid_i && !in_ready_o && !flush_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_inst_queue
//  Purpose  : Directed self-checking bench for fetch_inst_queue with a
//             queue-based reference model of the stored entries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_inst_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic [2:0]   in_count_i = 3'd0;
    logic [127:0] in_inst_i = '0;
    logic [127:0] in_pc_i = '0;
    logic [127:0] in_dest_i = '0;
    logic [3:0]   in_take_i = '0;
    logic         in_ready_o;
    logic [1:0]   out_valid_o;
    logic [63:0]  out_inst_o;
    logic [63:0]  out_pc_o;
    logic [63:0]  out_dest_o;
    logic [1:0]   out_take_o;
    logic [1:0]   out_pop_i = 2'd0;
    logic [4:0]   occupancy_o;
`ifdef FIQ_STALL_CNT_EN
    logic [31:0]  stall_cnt_o;
`endif

    fetch_inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_count_i  (in_count_i),
        .in_inst_i   (in_inst_i),
        .in_pc_i     (in_pc_i),
        .in_dest_i   (in_dest_i),
        .in_take_i   (in_take_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_inst_o  (out_inst_o),
        .out_pc_o    (out_pc_o),
        .out_dest_o  (out_dest_o),
        .out_take_o  (out_take_o),
        .out_pop_i   (out_pop_i),
        .occupancy_o (occupancy_o)
`ifdef FIQ_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        take;
        logic [31:0] dest;
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   exp_stall = 0;

    function automatic ent_t make_ent(input logic [31:0] pc);
        ent_t e;
        e.pc   = pc;
        e.inst = pc ^ 32'h1357_9BDF;
        e.dest = pc + 32'h0000_0040;
        e.take = pc[2] ^ pc[4];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = q.size();
        chk("occupancy", 64'(occupancy_o), 64'(sz));
        chk("in_ready", 64'(in_ready_o), 64'(sz <= 12));
        chk("out_valid", 64'(out_valid_o), (sz == 0) ? 64'd0 : (sz == 1) ? 64'd1 : 64'd3);
        if (sz >= 1) begin
            chk("slot0_pc", 64'(out_pc_o[31:0]), 64'(q[0].pc));
            chk("slot0_inst_dest", {out_dest_o[31:0], out_inst_o[31:0]}, {q[0].dest, q[0].inst});
            chk("slot0_take", 64'(out_take_o[0]), 64'(q[0].take));
        end
        if (sz >= 2) begin
            chk("slot1_pc", 64'(out_pc_o[63:32]), 64'(q[1].pc));
            chk("slot1_inst_dest", {out_dest_o[63:32], out_inst_o[63:32]}, {q[1].dest, q[1].inst});
            chk("slot1_take", 64'(out_take_o[1]), 64'(q[1].take));
        end
    endtask

    // Drive one cycle, check current outputs, then advance the model.
    task automatic step(input bit v, input int cnt, input logic [31:0] base,
                        input int pop, input bit fl);
        int   sz;
        int   eff;
        bit   acc;
        ent_t e;
        in_valid_i = v;
        in_count_i = 3'(cnt);
        out_pop_i  = 2'(pop);
        flush_i    = fl;
        for (int l = 0; l < 4; l++) begin
            e = make_ent(base + 32'(4 * l));
            in_pc_i[32*l +: 32]   = e.pc;
            in_inst_i[32*l +: 32] = e.inst;
            in_dest_i[32*l +: 32] = e.dest;
            in_take_i[l]          = e.take;
        end
        check_outputs();
        sz  = q.size();
        acc = v && (cnt >= 1) && (cnt <= 4) && (sz <= 12) && !fl;
        if (v && (sz > 12) && !fl) exp_stall++;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            eff = (pop > sz) ? sz : pop;
            if (eff > 2) eff = 2;
            for (int k = 0; k < eff; k++) void'(q.pop_front());
            if (acc) begin
                for (int l = 0; l < cnt; l++) q.push_back(make_ent(base + 32'(4 * l)));
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state, then a single 4-lane push.
        step(1, 4, 32'h8000_0000, 0, 0);
        chk("first_pc_pair", out_pc_o, 64'h8000_0004_8000_0000);
        chk("first_occ", 64'(occupancy_o), 64'd4);

        // Fill to capacity.
        step(1, 4, 32'h8000_0010, 0, 0);
        step(1, 4, 32'h8000_0020, 0, 0);
        step(1, 4, 32'h8000_0030, 0, 0);
        chk("full_occ", 64'(occupancy_o), 64'd16);
        chk("full_ready", 64'(in_ready_o), 64'd0);

        // Held bundle while full: must not be written.
        step(1, 4, 32'h9000_0000, 0, 0);
        step(1, 4, 32'h9000_0000, 0, 0);
        step(1, 4, 32'h9000_0000, 0, 0);
`ifdef FIQ_STALL_CNT_EN
        chk("stall_cnt_3", 64'(stall_cnt_o), 64'd3);
`endif

        // Drain two per cycle; ready returns at occupancy 12.
        for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 2, 0);

        // Preload 14 then drain so the next bundle starts at tail 14.
        step(1, 4, 32'hA000_0000, 0, 0);
        step(1, 4, 32'hA000_0010, 0, 0);
        step(1, 4, 32'hA000_0020, 0, 0);
        step(1, 2, 32'hA000_0030, 0, 0);
        chk("preload_occ", 64'(occupancy_o), 64'd14);
        for (int i = 0; i < 7; i++) step(0, 0, 32'h0, 2, 0);

        // Wrap-around bundle at indices 14,15,0,1, read back in order.
        step(1, 4, 32'hC000_0000, 0, 0);
        chk("wrap_pc_pair", out_pc_o, 64'hC000_0004_C000_0000);
        step(0, 0, 32'h0, 2, 0);
        chk("wrap_pc_pair2", out_pc_o, 64'hC000_000C_C000_0008);
        step(0, 0, 32'h0, 2, 0);

        // Simultaneous push 3 / pop 2 at occupancy 5.
        step(1, 4, 32'hD000_0000, 0, 0);
        step(1, 1, 32'hD000_0010, 0, 0);
        step(1, 3, 32'hD000_0100, 2, 0);
        chk("simul_occ", 64'(occupancy_o), 64'd6);

        // Flush at occupancy 9 with a bundle and a pop both present.
        step(1, 3, 32'hD000_0200, 0, 0);
        chk("preflush_occ", 64'(occupancy_o), 64'd9);
        step(1, 4, 32'hE000_0000, 2, 1);
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        chk("flush_ready", 64'(in_ready_o), 64'd1);

        // Over-pop at occupancy 1 and at empty.
        step(1, 1, 32'hF000_0000, 0, 0);
        step(0, 0, 32'h0, 2, 0);
        chk("overpop_occ", 64'(occupancy_o), 64'd0);
        step(0, 0, 32'h0, 3, 0);

        // Illegal lane counts are ignored.
        step(1, 0, 32'hF100_0000, 0, 0);
        step(1, 5, 32'hF200_0000, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk("illegal_occ", 64'(occupancy_o), 64'd0);

`ifdef FIQ_STALL_CNT_EN
        chk("stall_cnt_final", 64'(stall_cnt_o), 64'(exp_stall));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
